// File: rtl/ibex_mem_responder.sv
// Bounded-latency OBI-style memory slave for one Ibex port: stall inputs are turned into legal
// gnt/rvalid timing with guaranteed progress, backed by a zero-initialised word memory.
module ibex_mem_responder #(
  parameter int unsigned MEM_WORDS       = 64,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_GNT_STALL   = 3,
  parameter int unsigned MAX_RSP_STALL   = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_gnt_i,
  input  logic        stall_rsp_i,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned GCW   = $clog2(MAX_GNT_STALL + 2);
  localparam int unsigned RCW   = $clog2(MAX_RSP_STALL + 2);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [31:0]                mem_q [MEM_WORDS];
  logic [31:0]                fifo_rdata_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_err_q;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [GCW-1:0]             gnt_stall_q, gnt_stall_d;
  logic [RCW-1:0]             rsp_stall_q, rsp_stall_d;
  logic                       rvalid_q, err_q;
  logic [31:0]                rdata_q;
  logic                       pend_q, we_q, perr_q;
  logic [31:0]                addr_q, wdata_q;
  logic [3:0]                 be_q;

  logic             in_range_s, push_s, fifo_empty_s, fifo_full_s;
  logic             head_valid_s, rsp_fire_s, pop_s, wr_s, viol_s;
  logic             push_err_s, head_err_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      push_rdata_s, head_rdata_s;

  assign in_range_s   = (addr_i[31:2] < 30'(MEM_WORDS));
  assign idx_s        = addr_i[IDX_W+1:2];
  assign fifo_empty_s = (cnt_q == 3'd0);
  assign fifo_full_s  = (cnt_q >= 3'(MAX_OUTSTANDING));
  assign gnt_o        = rst_ni & req_i & ~fifo_full_s &
                        (~stall_gnt_i | (gnt_stall_q == GCW'(MAX_GNT_STALL)));
  assign push_s       = req_i & gnt_o;
  assign push_err_s   = ~in_range_s;
  assign push_rdata_s = (in_range_s & ~we_i) ? mem_q[idx_s] : 32'h0;

  // An empty FIFO lets the entry being granted respond at this edge (latency 1).
  assign head_valid_s = ~fifo_empty_s | push_s;
  assign head_rdata_s = fifo_empty_s ? push_rdata_s : fifo_rdata_q[rd_ptr_q];
  assign head_err_s   = fifo_empty_s ? push_err_s : fifo_err_q[rd_ptr_q];
  assign rsp_fire_s   = head_valid_s & (~stall_rsp_i | (rsp_stall_q == RCW'(MAX_RSP_STALL)));
  assign pop_s        = rsp_fire_s & ~fifo_empty_s;
  assign wr_s         = push_s & ~(fifo_empty_s & rsp_fire_s);

  assign viol_s = pend_q & (~req_i | (addr_i != addr_q) | (we_i != we_q) |
                            (be_i != be_q) | (wdata_i != wdata_q));

  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign err_o          = err_q;
  assign outstanding_o  = cnt_q;
  assign protocol_err_o = perr_q;

  always_comb begin
    gnt_stall_d = gnt_stall_q;
    rsp_stall_d = rsp_stall_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q + {2'b00, wr_s} - {2'b00, pop_s};
    if (~req_i | gnt_o) begin
      gnt_stall_d = GCW'(0);
    end else if (~fifo_full_s & (gnt_stall_q != GCW'(MAX_GNT_STALL))) begin
      gnt_stall_d = gnt_stall_q + GCW'(1);
    end else begin
      gnt_stall_d = gnt_stall_q;
    end
    if (rsp_fire_s) begin
      rsp_stall_d = RCW'(0);
    end else if (head_valid_s & (rsp_stall_q != RCW'(MAX_RSP_STALL))) begin
      rsp_stall_d = rsp_stall_q + RCW'(1);
    end else begin
      rsp_stall_d = rsp_stall_q;
    end
    if (wr_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (push_s & we_i & in_range_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx_s][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        fifo_rdata_q[i] <= 32'h0;
      end
      fifo_err_q <= '0;
    end else if (wr_s) begin
      fifo_rdata_q[wr_ptr_q] <= push_rdata_s;
      fifo_err_q[wr_ptr_q]   <= push_err_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q    <= PTR_W'(0);
      wr_ptr_q    <= PTR_W'(0);
      cnt_q       <= 3'd0;
      gnt_stall_q <= GCW'(0);
      rsp_stall_q <= RCW'(0);
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      perr_q      <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      gnt_stall_q <= gnt_stall_d;
      rsp_stall_q <= rsp_stall_d;
      rvalid_q    <= rsp_fire_s;
      rdata_q     <= rsp_fire_s ? head_rdata_s : 32'h0;
      err_q       <= rsp_fire_s & head_err_s;
      pend_q      <= req_i & ~gnt_o;
      addr_q      <= addr_i;
      wdata_q     <= wdata_i;
      we_q        <= we_i;
      be_q        <= be_i;
      perr_q      <= perr_q | viol_s;
    end
  end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Randomized bench for ibex_mem_responder: a queue-based reference model predicts every
// grant, response and flag from the memory-slave rules.
module tb_ibex_mem_responder;

  localparam int MEMW = 64;
  localparam int MAXO = 2;
  localparam int MAXG = 3;
  localparam int MAXR = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni, req_i, we_i, stall_gnt_i, stall_rsp_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o, protocol_err_o;
  logic [31:0] rdata_o;
  logic [2:0]  outstanding_o;

  ibex_mem_responder #(
    .MEM_WORDS(MEMW), .MAX_OUTSTANDING(MAXO), .MAX_GNT_STALL(MAXG), .MAX_RSP_STALL(MAXR)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .stall_gnt_i(stall_gnt_i), .stall_rsp_i(stall_rsp_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_err_r = 0;
  int n_chk_r = 0;

  // Reference state: memory image, in-order response queue, stall counters, protocol tracking.
  logic [31:0] m_mem [MEMW];
  logic [32:0] m_q [$];
  int          g_cnt, r_cnt;
  bit          m_perr, m_pend;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;
  logic [3:0]  p_be;
  bit          last_gnt, last_rv, last_err;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk_r++;
    if (got !== exp) begin
      n_err_r++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MEMW; i++) m_mem[i] = 32'h0;
    m_q.delete();
    g_cnt = 0; r_cnt = 0; m_perr = 1'b0; m_pend = 1'b0;
  endtask

  // Called just after a falling edge with inputs driven; runs one full clock cycle.
  task automatic cycle();
    bit          eg, viol, fire, inr;
    int          pre, idx;
    logic [32:0] ent;
    #1;
    pre = m_q.size();
    eg  = req_i && (pre < MAXO) && (!stall_gnt_i || g_cnt == MAXG);
    check("gnt", 32'(gnt_o), 32'(eg));
    last_gnt = gnt_o;
    viol = m_pend && (!req_i || addr_i !== p_addr || we_i !== p_we || be_i !== p_be || wdata_i !== p_wdata);
    if (viol) m_perr = 1'b1;
    idx = int'(addr_i[31:2]);
    inr = addr_i[31:2] < 30'(MEMW);
    if (eg) begin
      if (!inr) m_q.push_back({1'b1, 32'h0});
      else if (we_i) m_q.push_back({1'b0, 32'h0});
      else m_q.push_back({1'b0, m_mem[idx]});
      if (inr && we_i) begin
        for (int b = 0; b < 4; b++) if (be_i[b]) m_mem[idx][8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
    if (!req_i || eg) g_cnt = 0;
    else if (pre < MAXO && g_cnt < MAXG) g_cnt++;
    m_pend = req_i && !eg;
    p_addr = addr_i; p_we = we_i; p_be = be_i; p_wdata = wdata_i;
    fire = 1'b0;
    ent  = 33'h0;
    if (m_q.size() > 0) begin
      if (!stall_rsp_i || r_cnt == MAXR) begin
        fire = 1'b1; ent = m_q.pop_front(); r_cnt = 0;
      end else if (r_cnt < MAXR) begin
        r_cnt++;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    check("rvalid", 32'(rvalid_o), 32'(fire));
    check("rdata", rdata_o, ent[31:0]);
    check("err", 32'(err_o), 32'(ent[32]));
    check("outstanding", 32'(outstanding_o), 32'(m_q.size()));
    check("protocol_err", 32'(protocol_err_o), 32'(m_perr));
    last_rv = rvalid_o; last_rdata = rdata_o; last_err = err_o;
  endtask

  task automatic drive(input bit req, input logic [31:0] a, input bit we, input logic [3:0] be,
                       input logic [31:0] wd, input bit sg, input bit sr);
    req_i = req; addr_i = a; we_i = we; be_i = be; wdata_i = wd;
    stall_gnt_i = sg; stall_rsp_i = sr;
    cycle();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_i = 1'b1; addr_i = 32'h0; we_i = 1'b0; be_i = 4'hF;
    wdata_i = 32'h0; stall_gnt_i = 1'b0; stall_rsp_i = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt_o), 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_outstanding", 32'(outstanding_o), 32'h0);
    check("rst_protocol_err", 32'(protocol_err_o), 32'h0);
    model_reset();
    req_i  = 1'b0;
    rst_ni = 1'b1;
  endtask

  initial begin
    int n, n3;
    logic [31:0] a;
    rst_ni = 1'b0; req_i = 1'b0; addr_i = 32'h0; we_i = 1'b0; be_i = 4'h0;
    wdata_i = 32'h0; stall_gnt_i = 1'b0; stall_rsp_i = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Full-word write then read back with no stalls.
    drive(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
    check("t1_wr_gnt", 32'(last_gnt), 32'h1);
    drive(1'b1, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    check("t1_rd_rvalid", 32'(last_rv), 32'h1);
    check("t1_rd_rdata", last_rdata, 32'hDEADBEEF);

    // Partial byte-enable write into a zeroed word.
    drive(1'b1, 32'h8, 1'b1, 4'b0101, 32'h11223344, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    check("t2_rdata", last_rdata, 32'h00220044);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Grant stall bound with stall_gnt_i held high.
    n = 0;
    do begin
      drive(1'b1, 32'h20, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
      n++;
    end while (!last_gnt && n < 10);
    check("t3_gnt_cycles", 32'(n), 32'(MAXG + 1));
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Back-to-back reads with responses stalled: the third grant waits on a full FIFO.
    n3 = 0;
    for (int i = 0; i < 3; i++) begin
      a = 32'h8 + 32'(i * 8);
      n = 0;
      do begin
        drive(1'b1, a, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
        n++;
      end while (!last_gnt && n < 20);
      if (i == 2) n3 = n;
    end
    check("t4_third_waited", 32'(n3 > 1), 32'h1);
    repeat (12) drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    check("t4_drained", 32'(outstanding_o), 32'h0);

    // Out-of-range accesses: error response, memory untouched (index 64 must not alias index 0).
    drive(1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    check("t5_err", 32'(last_err), 32'h1);
    check("t5_rdata", last_rdata, 32'h0);
    drive(1'b1, 32'h100, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("t5_wr_err", 32'(last_err), 32'h1);
    drive(1'b1, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    check("t5_alias_rdata", last_rdata, 32'h0);

    // Random legal traffic checked cycle by cycle against the model.
    for (int c = 0; c < 600; c++) begin
      if (m_pend) begin
        drive(1'b1, p_addr, p_we, p_be, p_wdata, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      end else begin
        if ($urandom_range(0, 9) == 0) a = 32'(($urandom_range(64, 71)) << 2);
        else a = 32'(($urandom_range(0, 15)) << 2);
        a = a | 32'($urandom_range(0, 3));
        drive(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
              $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      end
    end

    // Protocol violation: request dropped while ungranted; sticky until reset.
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h30, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h30, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    check("t6_drop_perr", 32'(protocol_err_o), 32'h1);
    repeat (3) drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    check("t6_sticky", 32'(protocol_err_o), 32'h1);
    do_reset();
    check("t6_cleared", 32'(protocol_err_o), 32'h0);

    // Protocol violation: address changed while ungranted.
    drive(1'b1, 32'h30, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h34, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    check("t6_addr_perr", 32'(protocol_err_o), 32'h1);
    do_reset();

    // Memory re-zeroed by reset.
    drive(1'b1, 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    check("rst_mem_zero", last_rdata, 32'h0);
    check("rst_mem_rvalid", 32'(last_rv), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err_r, n_chk_r);
    $finish;
  end

endmodule
